// File: rtl/music_tone_gen.sv
// rtl/music_tone_gen.sv - multi-channel square-wave tone generator with per-note beat duration
module music_tone_gen #(
    parameter int CH       = 4,
    parameter int TICK_DIV = 100,
    parameter int BEAT_DIV = 5000000,
    parameter int DUR_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       note_valid,
    output logic                       note_ready,
    input  logic [2:0]                 note_ch,
    input  logic [4:0]                 note_code,
    input  logic [DUR_W-1:0]           note_dur,
    output logic [CH-1:0]              pwm,
    output logic [CH-1:0]              sd,
    output logic [$clog2(CH+1)-1:0]    mix,
    output logic                       busy,
    output logic                       ch_err
);
    localparam int MW = $clog2(CH + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    typedef enum logic {IDLE, PLAY} ch_state_t;

    function automatic logic [11:0] pitch(input logic [4:0] code);
        case (code)
            5'd1:  pitch = 12'd618;  5'd2:  pitch = 12'd583;  5'd3:  pitch = 12'd550;
            5'd4:  pitch = 12'd535;  5'd5:  pitch = 12'd505;  5'd6:  pitch = 12'd476;
            5'd7:  pitch = 12'd450;  5'd8:  pitch = 12'd437;  5'd9:  pitch = 12'd412;
            5'd10: pitch = 12'd389;  5'd11: pitch = 12'd378;  5'd12: pitch = 12'd357;
            5'd13: pitch = 12'd337;  5'd14: pitch = 12'd318;  5'd15: pitch = 12'd309;
            5'd16: pitch = 12'd291;  5'd17: pitch = 12'd275;  5'd18: pitch = 12'd267;
            5'd19: pitch = 12'd252;  5'd20: pitch = 12'd238;  5'd21: pitch = 12'd225;
            5'd22: pitch = 12'd425;  5'd23: pitch = 12'd277;  5'd24: pitch = 12'd218;
            5'd25: pitch = 12'd206;  5'd26: pitch = 12'd195;  5'd27: pitch = 12'd189;
            5'd28: pitch = 12'd178;  5'd29: pitch = 12'd168;  5'd30: pitch = 12'd159;
            5'd31: pitch = 12'd618;
            default: pitch = 12'd0;
        endcase
    endfunction

    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] beat_cnt;
    logic          tick, beat;
    logic          rdy_q;
    logic          accept;

    ch_state_t        state_q [CH];
    ch_state_t        state_d [CH];
    logic [11:0]      half_q  [CH];
    logic [11:0]      half_d  [CH];
    logic [11:0]      cnt_q   [CH];
    logic [11:0]      cnt_d   [CH];
    logic [DUR_W-1:0] dur_q   [CH];
    logic [DUR_W-1:0] dur_d   [CH];
    logic [CH-1:0]    pwm_q, pwm_d;
    logic [MW-1:0]    pop;

    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign beat       = (beat_cnt == BW'(BEAT_DIV - 1));
    assign note_ready = rdy_q && !rst;
    assign accept     = note_valid && note_ready;
    assign pwm        = pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            beat_cnt <= beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // An accepted command overrides any tick or expiry landing on the same edge.
    always_comb begin
        pwm_d = pwm_q;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            half_d[i]  = half_q[i];
            cnt_d[i]   = cnt_q[i];
            dur_d[i]   = dur_q[i];
            if (accept && note_ch == 3'(i)) begin
                cnt_d[i] = '0;
                pwm_d[i] = 1'b0;
                if (note_code == 5'd0) begin
                    state_d[i] = IDLE;
                    dur_d[i]   = '0;
                end else begin
                    state_d[i] = PLAY;
                    half_d[i]  = pitch(note_code);
                    dur_d[i]   = note_dur;
                end
            end else if (state_q[i] == PLAY) begin
                if (tick) begin
                    if (cnt_q[i] == half_q[i] - 12'd1) begin
                        cnt_d[i] = '0;
                        pwm_d[i] = !pwm_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 12'd1;
                    end
                end
                if (beat && dur_q[i] != '0) begin
                    if (dur_q[i] == DUR_W'(1)) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        dur_d[i]   = '0;
                        pwm_d[i]   = 1'b0;
                    end else begin
                        dur_d[i] = dur_q[i] - DUR_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sd  = '0;
        pop = '0;
        for (int i = 0; i < CH; i++) begin
            sd[i] = (state_q[i] == PLAY);
            pop   = pop + MW'(pwm_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            pwm_q  <= '0;
            mix    <= '0;
            busy   <= 1'b0;
            ch_err <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= IDLE;
                half_q[i]  <= '0;
                cnt_q[i]   <= '0;
                dur_q[i]   <= '0;
            end
        end else begin
            rdy_q  <= 1'b1;
            pwm_q  <= pwm_d;
            mix    <= pop;
            busy   <= |sd;
            ch_err <= accept && ({1'b0, note_ch} >= 4'(CH));
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                half_q[i]  <= half_d[i];
                cnt_q[i]   <= cnt_d[i];
                dur_q[i]   <= dur_d[i];
            end
        end
    end
endmodule
